// File: rtl/matrix_dma_ctrl.sv
// rtl/matrix_dma_ctrl.sv - bus-master sequencer feeding the matrix multiplier FIFOs
//
// Reads the A and B operands from memory over the shared bus, pushes them into
// the multiplier's A_FIFO / B_FIFO in the replay order the multiplier expects,
// writes the start register, then waits for the multiplier and raises an IRQ.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   s_sel/s_wr/s_addr/s_din/s_dout
//                         host register port (0 CTRL/STATUS, 1 A_BASE, 2 B_BASE)
//   m_req/m_grant/m_wr/m_address/m_dout/m_din
//                         bus master port; a cycle with m_req && m_grant completes
//   multi_opdone          multiplier done level
//   dma_interrupt         completion interrupt level, cleared by W1C on CTRL bit1
module matrix_dma_ctrl #(
    parameter int         MAT_DIM      = 2,
    parameter logic [7:0] FIFO_A_ADDR  = 8'h00,
    parameter logic [7:0] FIFO_B_ADDR  = 8'h01,
    parameter logic [7:0] OPSTART_ADDR = 8'h03
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [1:0]  s_addr,
    input  logic [31:0] s_din,
    output logic [31:0] s_dout,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_wr,
    output logic [7:0]  m_address,
    output logic [31:0] m_dout,
    input  logic [31:0] m_din,
    input  logic        multi_opdone,
    output logic        dma_interrupt
);

    typedef enum logic [2:0] {
        IDLE, RD_A, WR_A, RD_B, WR_B, START, WAIT_DONE, DONE
    } state_t;

    localparam logic [1:0] LAST_IDX  = 2'(MAT_DIM - 1);
    localparam logic [3:0] LAST_ELEM = 4'(MAT_DIM * MAT_DIM - 1);
    localparam logic [7:0] DIM8      = 8'(MAT_DIM);

    state_t     state;
    logic [7:0] a_base;
    logic [7:0] b_base;
    logic [1:0] cnt_row;
    logic [1:0] cnt_rep;
    logic [1:0] cnt_col;
    logic [3:0] cnt_elem;

    logic       busy;
    logic       reg_wr;
    logic       start_wr;
    logic       clr_wr;
    logic       col_last;
    logic       rep_last;
    logic       row_last;
    logic       elem_last;
    logic [1:0] a_col_nxt;
    logic [1:0] a_rep_nxt;
    logic [1:0] a_row_nxt;
    logic       a_feed_done;
    logic [7:0] a_addr_nxt;
    logic [3:0] b_elem_nxt;
    logic [1:0] b_rep_nxt;
    logic       b_feed_done;
    logic [7:0] b_addr_nxt;
    logic       unused_s_din;

    assign busy         = (state != IDLE) && (state != DONE);
    assign reg_wr       = s_sel && s_wr;
    assign start_wr     = reg_wr && (s_addr == 2'd0) && s_din[0];
    assign clr_wr       = reg_wr && (s_addr == 2'd0) && s_din[1];
    assign unused_s_din = ^s_din[31:8];

    // Next-word counters and addresses, so the registered m_address already
    // points at the following read when a write completes.
    always_comb begin
        col_last    = (cnt_col == LAST_IDX);
        rep_last    = (cnt_rep == LAST_IDX);
        row_last    = (cnt_row == LAST_IDX);
        elem_last   = (cnt_elem == LAST_ELEM);
        // A order: row, then replay of that row N times, then column.
        a_col_nxt   = col_last ? 2'd0 : cnt_col + 2'd1;
        a_rep_nxt   = col_last ? (rep_last ? 2'd0 : cnt_rep + 2'd1) : cnt_rep;
        a_row_nxt   = (col_last && rep_last) ? cnt_row + 2'd1 : cnt_row;
        a_feed_done = col_last && rep_last && row_last;
        a_addr_nxt  = a_base + 8'(a_row_nxt) * DIM8 + 8'(a_col_nxt);
        // B order: whole matrix replayed N times.
        b_elem_nxt  = elem_last ? 4'd0 : cnt_elem + 4'd1;
        b_rep_nxt   = elem_last ? cnt_rep + 2'd1 : cnt_rep;
        b_feed_done = elem_last && rep_last;
        b_addr_nxt  = b_base + 8'(b_elem_nxt);
    end

    // m_dout doubles as the hold register for the word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            a_base        <= 8'h20;
            b_base        <= 8'h40;
            cnt_row       <= 2'd0;
            cnt_rep       <= 2'd0;
            cnt_col       <= 2'd0;
            cnt_elem      <= 4'd0;
            m_req         <= 1'b0;
            m_wr          <= 1'b0;
            m_address     <= 8'h00;
            m_dout        <= 32'd0;
            dma_interrupt <= 1'b0;
        end else begin
            if (reg_wr && !busy) begin
                if (s_addr == 2'd1) a_base <= s_din[7:0];
                if (s_addr == 2'd2) b_base <= s_din[7:0];
            end
            if (clr_wr) dma_interrupt <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start_wr) begin
                        state     <= RD_A;
                        cnt_row   <= 2'd0;
                        cnt_rep   <= 2'd0;
                        cnt_col   <= 2'd0;
                        cnt_elem  <= 4'd0;
                        m_req     <= 1'b1;
                        m_wr      <= 1'b0;
                        m_address <= a_base;
                    end else if (state == DONE && clr_wr) begin
                        state <= IDLE;
                    end
                end
                RD_A: if (m_grant) begin
                    state     <= WR_A;
                    m_dout    <= m_din;
                    m_wr      <= 1'b1;
                    m_address <= FIFO_A_ADDR;
                end
                WR_A: if (m_grant) begin
                    m_wr <= 1'b0;
                    if (a_feed_done) begin
                        state     <= RD_B;
                        cnt_row   <= 2'd0;
                        cnt_rep   <= 2'd0;
                        cnt_col   <= 2'd0;
                        m_address <= b_base;
                    end else begin
                        state     <= RD_A;
                        cnt_row   <= a_row_nxt;
                        cnt_rep   <= a_rep_nxt;
                        cnt_col   <= a_col_nxt;
                        m_address <= a_addr_nxt;
                    end
                end
                RD_B: if (m_grant) begin
                    state     <= WR_B;
                    m_dout    <= m_din;
                    m_wr      <= 1'b1;
                    m_address <= FIFO_B_ADDR;
                end
                WR_B: if (m_grant) begin
                    if (b_feed_done) begin
                        state     <= START;
                        cnt_rep   <= 2'd0;
                        cnt_elem  <= 4'd0;
                        m_address <= OPSTART_ADDR;
                        m_dout    <= 32'd1;
                    end else begin
                        state     <= RD_B;
                        cnt_rep   <= b_rep_nxt;
                        cnt_elem  <= b_elem_nxt;
                        m_wr      <= 1'b0;
                        m_address <= b_addr_nxt;
                    end
                end
                START: if (m_grant) begin
                    state     <= WAIT_DONE;
                    m_req     <= 1'b0;
                    m_wr      <= 1'b0;
                    m_address <= 8'h00;
                    m_dout    <= 32'd0;
                end
                WAIT_DONE: if (multi_opdone) begin
                    state         <= DONE;
                    dma_interrupt <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_dout = 32'd0;
        case (s_addr)
            2'd0:    s_dout = {30'd0, dma_interrupt, busy};
            2'd1:    s_dout = {24'd0, a_base};
            2'd2:    s_dout = {24'd0, b_base};
            default: s_dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_matrix_dma_ctrl.sv
// tb/tb_matrix_dma_ctrl.sv - directed self-checking bench for matrix_dma_ctrl
module tb_matrix_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_sel;
    logic        s_wr;
    logic [1:0]  s_addr;
    logic [31:0] s_din;
    logic [31:0] s_dout;
    logic        m_req;
    logic        m_grant = 1'b1;
    logic        m_wr;
    logic [7:0]  m_address;
    logic [31:0] m_dout;
    logic [31:0] m_din;
    logic        multi_opdone;
    logic        dma_interrupt;

    logic [31:0] mem [0:255];

    matrix_dma_ctrl #(
        .MAT_DIM(2), .FIFO_A_ADDR(8'h00), .FIFO_B_ADDR(8'h01), .OPSTART_ADDR(8'h03)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout),
        .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr), .m_address(m_address),
        .m_dout(m_dout), .m_din(m_din),
        .multi_opdone(multi_opdone), .dma_interrupt(dma_interrupt)
    );

    always #5 clk = ~clk;

    assign m_din = mem[m_address];

    int n_cmp  = 0;
    int n_fail = 0;

    // Grant pattern: mode 0 continuous, mode 1 one cycle on / two off.
    int grant_mode = 0;
    int gcnt = 0;
    always @(negedge clk) begin
        gcnt = gcnt + 1;
        m_grant = (grant_mode == 0) ? 1'b1 : ((gcnt % 3) == 0);
    end

    // Bus monitor: logs every completed (requested and granted) cycle.
    logic [7:0]  rd_q [$];
    logic [39:0] wr_q [$];
    int gcyc = 0;
    int start_cyc = -1;
    always @(posedge clk) begin
        if (reset_n && m_req && m_grant) begin
            gcyc = gcyc + 1;
            if (m_wr) begin
                wr_q.push_back({m_address, m_dout});
                if (m_address == 8'h03) start_cyc = gcyc;
            end else begin
                rd_q.push_back(m_address);
            end
        end
    end

    logic [7:0] exp_rd [16] = '{8'h20, 8'h21, 8'h20, 8'h21, 8'h22, 8'h23, 8'h22, 8'h23,
                                8'h40, 8'h41, 8'h42, 8'h43, 8'h40, 8'h41, 8'h42, 8'h43};
    logic [39:0] exp_wr [17] = '{{8'h00, 32'd10}, {8'h00, 32'd11}, {8'h00, 32'd10}, {8'h00, 32'd11},
                                 {8'h00, 32'd12}, {8'h00, 32'd13}, {8'h00, 32'd12}, {8'h00, 32'd13},
                                 {8'h01, 32'd14}, {8'h01, 32'd16}, {8'h01, 32'd15}, {8'h01, 32'd17},
                                 {8'h01, 32'd14}, {8'h01, 32'd16}, {8'h01, 32'd15}, {8'h01, 32'd17},
                                 {8'h03, 32'd1}};
    logic [7:0]  exp_wrap_rd [8] = '{8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h01};
    logic [31:0] exp_wrap_wd [8] = '{32'd100, 32'd101, 32'd100, 32'd101, 32'd102, 32'd103, 32'd102, 32'd103};

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(posedge clk);
        #1;
        s_sel = 1'b0; s_wr = 1'b0; s_din = 32'd0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        s_addr = a;
        #1;
        d = s_dout;
    endtask

    task automatic start_run();
        rd_q.delete();
        wr_q.delete();
        gcyc = 0;
        start_cyc = -1;
        reg_write(2'd0, 32'd1);
    endtask

    task automatic wait_bus_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (!m_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_run();
        @(negedge clk); multi_opdone = 1'b1;
        @(negedge clk); multi_opdone = 1'b0;
        reg_write(2'd0, 32'd2);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %0b want 0", m_req); end
        n_cmp++; if (m_wr !== 1'b0) begin n_fail++; $display("FAIL reset_m_wr: got %0b want 0", m_wr); end
        n_cmp++; if (m_address !== 8'h00) begin n_fail++; $display("FAIL reset_m_address: got %0h want 0", m_address); end
        n_cmp++; if (m_dout !== 32'd0) begin n_fail++; $display("FAIL reset_m_dout: got %0h want 0", m_dout); end
        n_cmp++; if (dma_interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b want 0", dma_interrupt); end
        reg_read(2'd0, r);
        n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %0h want 0", r); end
        reg_read(2'd1, r);
        n_cmp++; if (r !== 32'h20) begin n_fail++; $display("FAIL reset_a_base: got %0h want 20", r); end
        reg_read(2'd2, r);
        n_cmp++; if (r !== 32'h40) begin n_fail++; $display("FAIL reset_b_base: got %0h want 40", r); end
        reg_read(2'd3, r);
        n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL reset_reg3: got %0h want 0", r); end
    endtask

    task automatic test_idle_opdone();
        logic [31:0] r;
        @(negedge clk); multi_opdone = 1'b1;
        repeat (2) @(negedge clk);
        multi_opdone = 1'b0;
        n_cmp++; if (dma_interrupt !== 1'b0) begin n_fail++; $display("FAIL idle_opdone_irq: got %0b want 0", dma_interrupt); end
        reg_read(2'd0, r);
        n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL idle_opdone_status: got %0h want 0", r); end
    endtask

    task automatic test_basic_feed();
        bit ok;
        start_run();
        n_cmp++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_rise: got %0b want 1", m_req); end
        n_cmp++; if (m_address !== 8'h20) begin n_fail++; $display("FAIL basic_first_addr: got %0h want 20", m_address); end
        wait_bus_done(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got busy want m_req low within 100 cycles"); end
        n_cmp++; if (start_cyc !== 33) begin n_fail++; $display("FAIL basic_opstart_cycle: got %0d want 33", start_cyc); end
        n_cmp++; if (gcyc !== 33) begin n_fail++; $display("FAIL basic_granted_cycles: got %0d want 33", gcyc); end
        n_cmp++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL basic_rd_count: got %0d want 16", rd_q.size()); end
        n_cmp++; if (wr_q.size() !== 17) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 17", wr_q.size()); end
        for (int j = 0; j < 16; j++) if (j < rd_q.size()) begin
            n_cmp++; if (rd_q[j] !== exp_rd[j]) begin n_fail++; $display("FAIL basic_rd[%0d]: got %0h want %0h", j, rd_q[j], exp_rd[j]); end
        end
        for (int j = 0; j < 17; j++) if (j < wr_q.size()) begin
            n_cmp++; if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL basic_wr[%0d]: got %0h want %0h", j, wr_q[j], exp_wr[j]); end
        end
    endtask

    task automatic test_irq();
        logic [31:0] r;
        repeat (5) @(negedge clk);
        n_cmp++; if (dma_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %0b want 0", dma_interrupt); end
        reg_read(2'd0, r);
        n_cmp++; if (r !== 32'd1) begin n_fail++; $display("FAIL irq_wait_status: got %0h want 1", r); end
        @(negedge clk); multi_opdone = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (dma_interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %0b want 1", dma_interrupt); end
        @(negedge clk); multi_opdone = 1'b0;
        reg_read(2'd0, r);
        n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL irq_done_status: got %0h want 2", r); end
        reg_write(2'd0, 32'd2);
        reg_read(2'd0, r);
        n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL irq_clear_status: got %0h want 0", r); end
        n_cmp++; if (dma_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %0b want 0", dma_interrupt); end
    endtask

    task automatic test_stall();
        bit ok;
        grant_mode = 1;
        start_run();
        wait_bus_done(400, ok);
        grant_mode = 0;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got busy want m_req low within 400 cycles"); end
        n_cmp++; if (start_cyc !== 33) begin n_fail++; $display("FAIL stall_opstart_cycle: got %0d want 33", start_cyc); end
        n_cmp++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL stall_rd_count: got %0d want 16", rd_q.size()); end
        n_cmp++; if (wr_q.size() !== 17) begin n_fail++; $display("FAIL stall_wr_count: got %0d want 17", wr_q.size()); end
        for (int j = 0; j < 16; j++) if (j < rd_q.size()) begin
            n_cmp++; if (rd_q[j] !== exp_rd[j]) begin n_fail++; $display("FAIL stall_rd[%0d]: got %0h want %0h", j, rd_q[j], exp_rd[j]); end
        end
        for (int j = 0; j < 17; j++) if (j < wr_q.size()) begin
            n_cmp++; if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL stall_wr[%0d]: got %0h want %0h", j, wr_q[j], exp_wr[j]); end
        end
        finish_run();
    endtask

    task automatic test_a_base_wrap();
        bit ok;
        logic [31:0] r;
        reg_write(2'd1, 32'hFE);
        reg_read(2'd1, r);
        n_cmp++; if (r !== 32'hFE) begin n_fail++; $display("FAIL wrap_a_base: got %0h want fe", r); end
        start_run();
        wait_bus_done(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got busy want m_req low within 100 cycles"); end
        n_cmp++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL wrap_rd_count: got %0d want 16", rd_q.size()); end
        for (int j = 0; j < 8; j++) if (j < rd_q.size() && j < wr_q.size()) begin
            n_cmp++; if (rd_q[j] !== exp_wrap_rd[j]) begin n_fail++; $display("FAIL wrap_rd[%0d]: got %0h want %0h", j, rd_q[j], exp_wrap_rd[j]); end
            n_cmp++; if (wr_q[j][31:0] !== exp_wrap_wd[j]) begin n_fail++; $display("FAIL wrap_wd[%0d]: got %0d want %0d", j, wr_q[j][31:0], exp_wrap_wd[j]); end
        end
        finish_run();
        reg_write(2'd1, 32'h20);
    endtask

    task automatic test_busy_ignore();
        bit ok;
        bit found;
        logic [31:0] r;
        start_run();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_req && m_wr && m_address == 8'h01) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL busy_find_wr_b: got none want WR_B within 100 cycles"); end
        s_sel = 1'b1; s_wr = 1'b1; s_addr = 2'd0; s_din = 32'd1;
        @(posedge clk); #1;
        s_addr = 2'd1; s_din = 32'h55;
        @(posedge clk); #1;
        s_addr = 2'd2; s_din = 32'h77;
        @(posedge clk); #1;
        s_sel = 1'b0; s_wr = 1'b0; s_din = 32'd0;
        wait_bus_done(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: got busy want m_req low within 100 cycles"); end
        n_cmp++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL busy_rd_count: got %0d want 16", rd_q.size()); end
        n_cmp++; if (wr_q.size() !== 17) begin n_fail++; $display("FAIL busy_wr_count: got %0d want 17", wr_q.size()); end
        for (int j = 0; j < 16; j++) if (j < rd_q.size()) begin
            n_cmp++; if (rd_q[j] !== exp_rd[j]) begin n_fail++; $display("FAIL busy_rd[%0d]: got %0h want %0h", j, rd_q[j], exp_rd[j]); end
        end
        for (int j = 0; j < 17; j++) if (j < wr_q.size()) begin
            n_cmp++; if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL busy_wr[%0d]: got %0h want %0h", j, wr_q[j], exp_wr[j]); end
        end
        reg_read(2'd1, r);
        n_cmp++; if (r !== 32'h20) begin n_fail++; $display("FAIL busy_a_base: got %0h want 20", r); end
        reg_read(2'd2, r);
        n_cmp++; if (r !== 32'h40) begin n_fail++; $display("FAIL busy_b_base: got %0h want 40", r); end
        finish_run();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        int nrd;
        int nwr;
        logic [31:0] r;
        start_run();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_req && !m_wr && m_address == 8'h40) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rst_find_rd_b: got none want RD_B within 100 cycles"); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_m_req: got %0b want 0", m_req); end
        n_cmp++; if (m_wr !== 1'b0) begin n_fail++; $display("FAIL rst_m_wr: got %0b want 0", m_wr); end
        n_cmp++; if (m_address !== 8'h00) begin n_fail++; $display("FAIL rst_m_address: got %0h want 0", m_address); end
        n_cmp++; if (m_dout !== 32'd0) begin n_fail++; $display("FAIL rst_m_dout: got %0h want 0", m_dout); end
        n_cmp++; if (dma_interrupt !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %0b want 0", dma_interrupt); end
        reg_read(2'd0, r);
        n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL rst_status: got %0h want 0", r); end
        nrd = rd_q.size();
        nwr = wr_q.size();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle_req: got %0b want 0", m_req); end
        n_cmp++; if (rd_q.size() + wr_q.size() !== nrd + nwr) begin
            n_fail++; $display("FAIL rst_no_bus: got %0d cycles want %0d", rd_q.size() + wr_q.size(), nrd + nwr);
        end
        start_run();
        wait_bus_done(100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_rerun_timeout: got busy want m_req low within 100 cycles"); end
        n_cmp++; if (rd_q.size() !== 16) begin n_fail++; $display("FAIL rst_rerun_rd_count: got %0d want 16", rd_q.size()); end
        n_cmp++; if (wr_q.size() !== 17) begin n_fail++; $display("FAIL rst_rerun_wr_count: got %0d want 17", wr_q.size()); end
        for (int j = 0; j < 16; j++) if (j < rd_q.size()) begin
            n_cmp++; if (rd_q[j] !== exp_rd[j]) begin n_fail++; $display("FAIL rst_rerun_rd[%0d]: got %0h want %0h", j, rd_q[j], exp_rd[j]); end
        end
        for (int j = 0; j < 17; j++) if (j < wr_q.size()) begin
            n_cmp++; if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL rst_rerun_wr[%0d]: got %0h want %0h", j, wr_q[j], exp_wr[j]); end
        end
        finish_run();
    endtask

    initial begin
        reset_n = 1'b0;
        s_sel = 1'b0; s_wr = 1'b0; s_addr = 2'd0; s_din = 32'd0;
        multi_opdone = 1'b0;
        for (int j = 0; j < 256; j++) mem[j] = 32'd0;
        mem[8'h20] = 32'd10; mem[8'h21] = 32'd11; mem[8'h22] = 32'd12; mem[8'h23] = 32'd13;
        mem[8'h40] = 32'd14; mem[8'h41] = 32'd16; mem[8'h42] = 32'd15; mem[8'h43] = 32'd17;
        mem[8'hFE] = 32'd100; mem[8'hFF] = 32'd101; mem[8'h00] = 32'd102; mem[8'h01] = 32'd103;

        test_reset();
        test_idle_opdone();
        test_basic_feed();
        test_irq();
        test_stall();
        test_a_base_wrap();
        test_busy_ignore();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
